unified_mem_ctrl: RTL

UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

---
 rtl/unified_mem_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: single-port word memory shared by a read-only fetch port and a load/store data port,
// arbitrated round-robin through an IDLE/ACCESS/RESP FSM with configurable wait states.
module unified_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, be_q, be_d;
  logic        rr_q, rr_d, gnt_q, gnt_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] rd;
  logic        fault, pick_d, done, mem_we;
  assign idx    = addr_q[AW+1:2];
  assign rd     = mem[idx];
  assign fault  = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * DEPTH));
  // rr_q = 1 means the data port was granted last, so fetch wins the next tie
  assign pick_d = d_req && (!if_req || !rr_q);
  assign done   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign mem_we = done && we_q && !fault;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign err      = err_q;
  assign busy     = state_q != IDLE;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = if_ack_q;
    d_ack_d    = d_ack_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (if_req || d_req) begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_STATES);
        gnt_d   = pick_d;
        rr_d    = pick_d;
        addr_d  = pick_d ? d_addr : if_addr;
        we_d    = pick_d && d_we;
        be_d    = d_be;
        wdata_d = d_wdata;
      end
      ACCESS: begin
        state_d = done ? RESP : ACCESS;
        cnt_d   = done ? cnt_q : cnt_q - 4'd1;
        if (done) begin
          if_ack_d   = !gnt_q;
          d_ack_d    = gnt_q;
          err_d      = fault;
          if_rdata_d = gnt_q ? if_rdata_q : (fault ? '0 : rd);
          d_rdata_d  = !gnt_q ? d_rdata_q : fault ? '0 : we_q ? d_rdata_q : rd;
        end
      end
      RESP: begin
        state_d  = IDLE;
        if_ack_d = 1'b0;
        d_ack_d  = 1'b0;
        err_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
    end
  end
  // Storage is deliberately outside the reset domain; a reset forces IDLE so no write can fire
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule
